arbitro_barramento: RTL and testbench
=====================================

ARBITRO_BARRAMENTO -- requirements
Module: arbitro_barramento

Interface
REQ-001 Parameter N_PORTAS, default 6, number of bus ports; ports 0..5 are pilha, memoria, temp1, temp2, ula, uc.
REQ-002 Parameter LARG_IDX, default 3, width of a port index.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  N_PORTAS  req[i]=1 means port i asks to write (drive) the bus.
REQ-006 dest  input  N_PORTAS*LARG_IDX  slice i holds the target (reader) port index of requester i.
REQ-007 ctrl_0..ctrl_5  output  2 each  bus port control; bit1 = write/drive, bit0 = read; 2'b00 = idle.
REQ-008 gnt  output  N_PORTAS  one-hot; the current transfer's source, held SETUP through XFER.
REQ-009 done  output  N_PORTAS  one-cycle pulse to the source on transfer completion.
REQ-010 err  output  N_PORTAS  one-cycle pulse to a requester whose dest is invalid.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 FSM states: IDLE, SETUP, XFER, DONE, ERR; all outputs registered.
REQ-013 IDLE: if any req bit set, select a winner by round-robin, starting the search at (ptr+1) mod N_PORTAS.
REQ-014 IDLE to SETUP when the winner's dest is valid; IDLE to ERR otherwise; IDLE holds when req == 0.
REQ-015 Valid dest: less than N_PORTAS and not equal to the source index.
REQ-016 SETUP (1 cycle): ctrl_src=2'b10, all other ctrl=2'b00, gnt[src]=1; the bus is driven before the reader is enabled.
REQ-017 XFER (1 cycle): ctrl_src=2'b10, ctrl_dst=2'b01, others 2'b00, gnt[src]=1.
REQ-018 DONE (1 cycle): all ctrl=2'b00, gnt=0, done[src]=1, ptr<=src; next state IDLE.
REQ-019 ERR (1 cycle): all ctrl=2'b00, err[src]=1, ptr<=src; next state IDLE.
REQ-020 Latency from req sampled in IDLE to done pulse is 3 cycles; the next grant comes no earlier than 1 cycle after DONE.
REQ-021 req and dest are sampled only in IDLE; source and dest are latched there.
REQ-022 Dropping req after the grant does not abort the transfer.
REQ-023 At no time may two ctrl outputs have bit1 set, or any ctrl output equal 2'b11.
REQ-024 Simultaneous requests are resolved by the rotating priority only; ptr wraps from N_PORTAS-1 to 0.
REQ-025 A requester holding req continuously is re-granted only after all other pending requesters are served.

Reset
REQ-026 While rst_n=0, asynchronously: state=IDLE, ctrl_*=2'b00, gnt=0, done=0, err=0, busy=0, ptr=N_PORTAS-1.
REQ-027 Reset asserted mid-transfer releases the bus immediately; no done or err pulse is issued for the aborted transfer.

Configuration
REQ-028 Macro ARB_PRIO_UC_EN defined: port 5 (uc), if requesting in IDLE, always wins; ptr is not updated by uc grants.
REQ-029 Macro ARB_PRIO_UC_EN undefined: pure round-robin over all ports, port 5 included.

Structure
REQ-030 Shared package barramento_pkg holds the state enum, N_PORTAS, LARG_IDX, and the ctrl encodings CTRL_IDLE, CTRL_LER, CTRL_ESCR.
REQ-031 Winner selection lives in a combinational sub-module rr_seletor with inputs req and ptr, and outputs a one-hot result plus its index.

Verification
REQ-032 Single request: req=6'b000100, dest_2=1 -> ctrl_2=10 at T+1, T+2 with ctrl_1=01 at T+2, done[2]=1 at T+3, busy low at T+4.
REQ-033 All six requesting after reset -> grant order 0,1,2,3,4,5,0 (without macro), each transfer 4 cycles apart.
REQ-034 Invalid dest: req[3]=1, dest_3=3, then dest_3=7 -> err[3] pulse each time; all ctrl stay 00; no done pulse.
REQ-035 rst_n pulled low during XFER -> all ctrl 00 asynchronously, no done pulse; after release, a pending req is granted from port 0.
REQ-036 With ARB_PRIO_UC_EN defined, req=6'b100011 -> uc first, then 0, then 1; assertion checks REQ-023 throughout.

Source files
------------

// File: rtl/barramento_pkg.sv
// Shared types and constants for the six-port bus arbiter (pilha, memoria, temp1, temp2, ula, uc).
package barramento_pkg;

    localparam int N_PORTAS = 6;
    localparam int LARG_IDX = 3;
    localparam int UC_IDX   = 5;

    localparam logic [1:0] CTRL_IDLE = 2'b00;
    localparam logic [1:0] CTRL_LER  = 2'b01;
    localparam logic [1:0] CTRL_ESCR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } estado_t;

    // A target is usable when it names an existing port other than the source itself.
    function automatic logic dest_valido(input logic [LARG_IDX-1:0] dst,
                                         input logic [LARG_IDX-1:0] src,
                                         input int                  n_portas);
        return (int'(dst) < n_portas) && (dst != src);
    endfunction

endpackage

// File: rtl/rr_seletor.sv
// Combinational round-robin winner search; the search starts at the port after ptr and wraps.
module rr_seletor #(
    parameter int N_PORTAS = barramento_pkg::N_PORTAS,
    parameter int LARG_IDX = barramento_pkg::LARG_IDX
) (
    input  logic [N_PORTAS-1:0] req,
    input  logic [LARG_IDX-1:0] ptr,
    output logic [N_PORTAS-1:0] sel,
    output logic [LARG_IDX-1:0] idx
);

    logic [LARG_IDX-1:0] cand_s;
    logic                achou_s;

    // Walk ptr+1, ptr+2, ... modulo N_PORTAS and keep the first requester found.
    always_comb begin
        sel     = '0;
        idx     = '0;
        cand_s  = '0;
        achou_s = 1'b0;
        for (int k = 1; k <= N_PORTAS; k++) begin
            cand_s  = LARG_IDX'((int'(ptr) + k) % N_PORTAS);
            idx     = (!achou_s && req[cand_s]) ? cand_s : idx;
            achou_s = achou_s | req[cand_s];
        end
        sel[idx] = achou_s;
    end

endmodule

// File: rtl/arbitro_barramento.sv
// Bus arbiter: one writer and one reader per transfer, sequenced SETUP -> XFER -> DONE.
// Optional build macro ARB_PRIO_UC_EN gives port 5 (uc) absolute priority in IDLE.
module arbitro_barramento #(
    parameter int N_PORTAS = barramento_pkg::N_PORTAS,
    parameter int LARG_IDX = barramento_pkg::LARG_IDX
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_PORTAS-1:0]          req,
    input  logic [N_PORTAS*LARG_IDX-1:0] dest,
    output logic [1:0]                   ctrl_0,
    output logic [1:0]                   ctrl_1,
    output logic [1:0]                   ctrl_2,
    output logic [1:0]                   ctrl_3,
    output logic [1:0]                   ctrl_4,
    output logic [1:0]                   ctrl_5,
    output logic [N_PORTAS-1:0]          gnt,
    output logic [N_PORTAS-1:0]          done,
    output logic [N_PORTAS-1:0]          err,
    output logic                         busy
);
    import barramento_pkg::*;

    estado_t                       estado_r, estado_nx_s;
    logic [LARG_IDX-1:0]           src_r, src_nx_s, dst_r, dst_nx_s, ptr_r, ptr_nx_s;
    logic [N_PORTAS-1:0][1:0]      ctrl_r, ctrl_nx_s;
    logic [N_PORTAS-1:0]           gnt_r, gnt_nx_s, done_r, done_nx_s, err_r, err_nx_s;
    logic                          busy_r, busy_nx_s;
    logic [N_PORTAS-1:0]           rr_sel_s;
    logic [LARG_IDX-1:0]           rr_idx_s, venc_idx_s;
    logic [LARG_IDX-1:0]           dest_arr_s [N_PORTAS];
    logic                          tem_req_s;

    for (genvar g = 0; g < N_PORTAS; g++) begin : g_dest
        assign dest_arr_s[g] = dest[g*LARG_IDX +: LARG_IDX];
    end

    rr_seletor #(.N_PORTAS(N_PORTAS), .LARG_IDX(LARG_IDX)) u_rr_seletor (
        .req (req),
        .ptr (ptr_r),
        .sel (rr_sel_s),
        .idx (rr_idx_s)
    );

    assign tem_req_s = |rr_sel_s;

    // Winner of the IDLE decision; uc pre-empts the rotation only in the priority build.
    always_comb begin
`ifdef ARB_PRIO_UC_EN
        venc_idx_s = req[UC_IDX] ? LARG_IDX'(UC_IDX) : rr_idx_s;
`else
        venc_idx_s = rr_idx_s;
`endif
    end

    // Next state plus the outputs that belong to the state being entered.
    always_comb begin
        estado_nx_s = estado_r;
        src_nx_s    = src_r;
        dst_nx_s    = dst_r;
        ptr_nx_s    = ptr_r;
        case (estado_r)
            ST_IDLE: begin
                if (tem_req_s) begin
                    src_nx_s    = venc_idx_s;
                    dst_nx_s    = dest_arr_s[venc_idx_s];
                    estado_nx_s = dest_valido(dest_arr_s[venc_idx_s], venc_idx_s, N_PORTAS)
                                  ? ST_SETUP : ST_ERR;
                end else begin
                    estado_nx_s = ST_IDLE;
                end
            end
            ST_SETUP: estado_nx_s = ST_XFER;
            ST_XFER:  estado_nx_s = ST_DONE;
            ST_DONE, ST_ERR: begin
                estado_nx_s = ST_IDLE;
`ifdef ARB_PRIO_UC_EN
                ptr_nx_s    = (src_r == LARG_IDX'(UC_IDX)) ? ptr_r : src_r;
`else
                ptr_nx_s    = src_r;
`endif
            end
            default:  estado_nx_s = ST_IDLE;
        endcase

        ctrl_nx_s = '0;
        gnt_nx_s  = '0;
        done_nx_s = '0;
        err_nx_s  = '0;
        busy_nx_s = (estado_nx_s != ST_IDLE);
        case (estado_nx_s)
            ST_SETUP: begin
                ctrl_nx_s[src_nx_s] = CTRL_ESCR;
                gnt_nx_s[src_nx_s]  = 1'b1;
            end
            ST_XFER: begin
                ctrl_nx_s[src_nx_s] = CTRL_ESCR;
                ctrl_nx_s[dst_nx_s] = CTRL_LER;
                gnt_nx_s[src_nx_s]  = 1'b1;
            end
            ST_DONE: done_nx_s[src_nx_s] = 1'b1;
            ST_ERR:  err_nx_s[src_nx_s]  = 1'b1;
            default: ctrl_nx_s = '0;
        endcase
    end

    // State register and the transfer context latched in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_r <= ST_IDLE;
            src_r    <= '0;
            dst_r    <= '0;
            ptr_r    <= LARG_IDX'(N_PORTAS - 1);
        end else begin
            estado_r <= estado_nx_s;
            src_r    <= src_nx_s;
            dst_r    <= dst_nx_s;
            ptr_r    <= ptr_nx_s;
        end
    end

    // Output registers; reset drops the bus at once and swallows any pending pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_r <= '0;
            gnt_r  <= '0;
            done_r <= '0;
            err_r  <= '0;
            busy_r <= 1'b0;
        end else begin
            ctrl_r <= ctrl_nx_s;
            gnt_r  <= gnt_nx_s;
            done_r <= done_nx_s;
            err_r  <= err_nx_s;
            busy_r <= busy_nx_s;
        end
    end

    assign ctrl_0 = ctrl_r[3'd0];
    assign ctrl_1 = ctrl_r[3'd1];
    assign ctrl_2 = ctrl_r[3'd2];
    assign ctrl_3 = ctrl_r[3'd3];
    assign ctrl_4 = ctrl_r[3'd4];
    assign ctrl_5 = ctrl_r[3'd5];
    assign gnt    = gnt_r;
    assign done   = done_r;
    assign err    = err_r;
    assign busy   = busy_r;

endmodule

// File: tb/tb_arbitro_barramento.sv
// Scoreboard bench: a transaction-level model queues expected output cycles, a monitor compares.
module tb_arbitro_barramento;

    localparam int N = 6;
    localparam int L = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*L-1:0] dest = '0;
    logic [1:0]     ctrl_0, ctrl_1, ctrl_2, ctrl_3, ctrl_4, ctrl_5;
    logic [N-1:0]   gnt, done, err;
    logic           busy;

    arbitro_barramento dut (
        .clk(clk), .rst_n(rst_n), .req(req), .dest(dest),
        .ctrl_0(ctrl_0), .ctrl_1(ctrl_1), .ctrl_2(ctrl_2),
        .ctrl_3(ctrl_3), .ctrl_4(ctrl_4), .ctrl_5(ctrl_5),
        .gnt(gnt), .done(done), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        logic [N-1:0] gnt;
        logic [N-1:0] done;
        logic [N-1:0] err;
        logic [2*N-1:0] ctrl;
    } exp_t;

    exp_t         fila[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc = 0;
    bit           mon_en = 1'b0;
    logic [N-1:0] pend = '0;
    logic [L-1:0] dv [N];
    int           m_ptr = N - 1;
    int           cd = 0;
    bit           hold = 1'b0;

    task automatic cmp(input string nome, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nome, act, expv, cyc);
        end
    endtask

    // Reference: a granted valid transfer shows SETUP, XFER, DONE in the next three cycles.
    task automatic agendar(input int w);
        exp_t e;
        int   d;
        d = int'(dv[w]);
        if (d < N && d != w) begin
            for (int s = 1; s <= 3; s++) begin
                e.cyc = cyc + s; e.gnt = '0; e.done = '0; e.err = '0; e.ctrl = '0;
                if (s < 3) begin
                    e.gnt[w] = 1'b1;
                    e.ctrl[2*w+1] = 1'b1;
                end
                if (s == 2) e.ctrl[2*d] = 1'b1;
                if (s == 3) e.done[w] = 1'b1;
                fila.push_back(e);
            end
            cd = 4;
        end else begin
            e.cyc = cyc + 1; e.gnt = '0; e.done = '0; e.err = '0; e.ctrl = '0;
            e.err[w] = 1'b1;
            fila.push_back(e);
            cd = 2;
        end
`ifdef ARB_PRIO_UC_EN
        if (w != 5) m_ptr = w;
`else
        m_ptr = w;
`endif
    endtask

    // One cycle of stimulus; the model decides whenever the arbiter is free to sample.
    task automatic tick();
        int w;
        @(negedge clk);
        if (cd > 0) cd--;
        req = pend;
        for (int i = 0; i < N; i++) dest[i*L +: L] = dv[i];
        if (cd == 0 && pend != '0) begin
            w = -1;
`ifdef ARB_PRIO_UC_EN
            if (pend[5]) w = 5;
`endif
            for (int k = 1; k <= N && w < 0; k++)
                if (pend[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            agendar(w);
            if (!hold) pend[w] = 1'b0;
        end
    endtask

    // Monitor: bus exclusivity every cycle, and queued expectations whenever the DUT shows output.
    always begin : monitor
        exp_t         e;
        logic [2*N-1:0] act_ctrl;
        int           nw;
        bit           tres;
        @(posedge clk);
        #1;
        cyc++;
        act_ctrl = {ctrl_5, ctrl_4, ctrl_3, ctrl_2, ctrl_1, ctrl_0};
        nw = 0; tres = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (act_ctrl[2*i+1]) nw++;
            if (act_ctrl[2*i +: 2] == 2'b11) tres = 1'b1;
        end
        cmp("ctrl_exclusive", 64'((nw > 1) || tres), 64'd0);
        if (mon_en) begin
            while (fila.size() > 0 && fila[0].cyc < cyc) begin
                n_cmp++; n_err++;
                $display("FAIL missing_output: expected at cycle %0d, not seen by cycle %0d", fila[0].cyc, cyc);
                void'(fila.pop_front());
            end
            if ((gnt | done | err) != '0) begin
                if (fila.size() == 0 || fila[0].cyc != cyc) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_output: gnt=%b done=%b err=%b ctrl=%h at cycle %0d, expected none",
                             gnt, done, err, act_ctrl, cyc);
                end else begin
                    e = fila.pop_front();
                    cmp("transfer_out", 64'({busy, gnt, done, err, act_ctrl}),
                        64'({1'b1, e.gnt, e.done, e.err, e.ctrl}));
                end
            end else begin
                cmp("idle_out", 64'({busy, act_ctrl}), 64'd0);
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) dv[i] = L'((i + 1) % N);
        repeat (3) @(negedge clk);
        cmp("reset_state", 64'({ctrl_5, ctrl_4, ctrl_3, ctrl_2, ctrl_1, ctrl_0, gnt, done, err, busy}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // All six holding req: rotation 0,1,2,3,4,5,0, one grant every four cycles.
        hold = 1'b1;
        pend = 6'b111111;
        repeat (25) tick();
        hold = 1'b0;
        pend = '0;
        repeat (6) tick();

        // Single request from temp1 to memoria.
        pend = 6'b000100; dv[2] = 3'd1;
        repeat (6) tick();

        // Invalid targets: self, then out of range.
        pend[3] = 1'b1; dv[3] = 3'd3;
        repeat (3) tick();
        pend[3] = 1'b1; dv[3] = 3'd7;
        repeat (3) tick();
        dv[3] = 3'd4;

        // Reset asserted during XFER: bus released immediately, no completion pulse.
        repeat (4) tick();
        pend = 6'b000100; dv[2] = 3'd1;
        repeat (3) tick();
        rst_n = 1'b0;
        mon_en = 1'b0;
        #1;
        cmp("async_reset_ctrl", 64'({ctrl_5, ctrl_4, ctrl_3, ctrl_2, ctrl_1, ctrl_0, gnt, busy}), 64'd0);
        fila.delete();
        cd = 0;
        m_ptr = N - 1;
        repeat (2) begin
            @(posedge clk);
            #2;
            cmp("no_pulse_in_reset", 64'({done, err}), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        pend = 6'b011001; dv[0] = 3'd1; dv[3] = 3'd4; dv[4] = 3'd0;
        repeat (14) tick();

        // Randomized traffic with occasional invalid targets.
        repeat (400) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    dv[i] = L'($urandom_range(0, 7));
                end
            end
            tick();
        end
        pend = '0;
        repeat (10) tick();
        cmp("scoreboard_drained", 64'(fila.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
